bpsk_dac_gen: RTL and testbench

- Parametrised single-clock BPSK baseband generator feeding a 14-bit-class offset-binary DAC.
- Generates its own symbol-rate strobe from a runtime divider, replacing a separate slow symbol clock.
- Symbol source is an internal PRBS. Symbols are mapped to ±amplitude, offset and saturated into the DAC code range, and gated by a programmable burst window (period/on-time counter).
- Sits between the reset/clock generation and the DAC output ODDR/pin logic; DAC clock/write strobes stay outside this block.

---
 rtl/bpsk_pkg.sv | 32 +++
 rtl/prbs_gen.sv | 29 ++
 rtl/bpsk_dac_gen.sv | 168 ++++++++++++++++
 tb/tb_bpsk_dac_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared constants and helpers for the BPSK DAC generator:
// LFSR tap masks, DAC mid-scale and clip limits.
package bpsk_pkg;

    // Fibonacci tap masks (bit i set = stage i feeds the XOR), shift-left LFSR
    localparam logic [31:0] TAPS_7  = 32'h0000_0060;  // x^7  + x^6  + 1
    localparam logic [31:0] TAPS_15 = 32'h0000_6000;  // x^15 + x^14 + 1
    localparam logic [31:0] TAPS_23 = 32'h0042_0000;  // x^23 + x^18 + 1

    function automatic logic [31:0] prbs_taps(input int len);
        case (len)
            7:       return TAPS_7;
            23:      return TAPS_23;
            default: return TAPS_15;
        endcase
    endfunction

    // Offset-binary mid-scale code (idle level after reset)
    function automatic int mid_code(input int dac_w);
        return 1 << (dac_w - 1);
    endfunction

    // Saturation limits of the DAC code range
    function automatic int min_code();
        return 0;
    endfunction

    function automatic int max_code(input int dac_w);
        return (1 << dac_w) - 1;
    endfunction

endpackage

// File: rtl/prbs_gen.sv
// Fibonacci LFSR symbol source. bit_o is the bit that enters the register
// on the next advance, so the consumer can register it in the same edge.
module prbs_gen
    import bpsk_pkg::*;
#(
    parameter int PRBS_LEN = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    output logic bit_o
);

    localparam logic [PRBS_LEN-1:0] TAPS = PRBS_LEN'(prbs_taps(PRBS_LEN));

    logic [PRBS_LEN-1:0] lfsr;

    assign bit_o = ^(lfsr & TAPS);

    // All-ones seed keeps the register out of the lock-up state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= '1;
        end else if (adv) begin
            lfsr <= {lfsr[PRBS_LEN-2:0], bit_o};
        end
    end

endmodule

// File: rtl/bpsk_dac_gen.sv
// BPSK baseband generator: symbol-rate strobe, PRBS symbols, +/-amp mapping
// around dac_offset with clipping, gated by a period/on-time burst window.
// Optional build macro BPSK_DIFF_ENC_EN adds input diff_en (DBPSK encoding).
module bpsk_dac_gen
    import bpsk_pkg::*;
#(
    parameter int DAC_W    = 14,
    parameter int AMP_W    = 13,
    parameter int DIV_W    = 16,
    parameter int BURST_W  = 24,
    parameter int PRBS_LEN = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
`ifdef BPSK_DIFF_ENC_EN
    input  logic               diff_en,
`endif
    input  logic [DIV_W-1:0]   sym_div,
    input  logic [AMP_W-1:0]   amp,
    input  logic [DAC_W-1:0]   dac_offset,
    input  logic [BURST_W-1:0] burst_period,
    input  logic [BURST_W-1:0] burst_on,
    output logic               sym_bit,
    output logic               sym_strobe,
    output logic               gate,
    output logic [DAC_W-1:0]   dac_data,
    output logic               sat
);

    localparam int SUM_W = DAC_W + 2;
    localparam logic [DAC_W-1:0]        MID_CODE = DAC_W'(mid_code(DAC_W));
    localparam logic [DAC_W-1:0]        MIN_CODE = DAC_W'(min_code());
    localparam logic [DAC_W-1:0]        MAX_CODE = DAC_W'(max_code(DAC_W));
    localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'(max_code(DAC_W));

    logic               en_d;
    logic               en_rise;
    logic [DIV_W-1:0]   sym_cnt;
    logic [DIV_W-1:0]   sym_div_l;
    logic [DIV_W-1:0]   div_eff;
    logic               sym_wrap;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] period_l;
    logic [BURST_W-1:0] on_l;
    logic [BURST_W-1:0] period_eff;
    logic [BURST_W-1:0] on_eff;
    logic               burst_wrap;
    logic               gate_next;
    logic               prbs_bit;
    logic               next_bit;
    logic signed [AMP_W:0]   mapped;
    logic signed [SUM_W-1:0] sum;
    logic [DAC_W-1:0]   clip_code;
    logic               clip;

    assign en_rise = en & ~en_d;

    // On the first enabled cycle the live divider is used, otherwise the latched one
    always_comb begin
        div_eff  = en_rise ? sym_div : sym_div_l;
        sym_wrap = en && (sym_cnt == div_eff);
    end

    // Symbol counter, strobe and divider latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d       <= 1'b0;
            sym_cnt    <= '0;
            sym_div_l  <= '0;
            sym_strobe <= 1'b0;
        end else begin
            en_d <= en;
            if (!en) begin
                sym_cnt    <= '0;
                sym_strobe <= 1'b0;
            end else begin
                sym_strobe <= sym_wrap;
                sym_cnt    <= sym_wrap ? '0 : sym_cnt + DIV_W'(1);
                if (sym_wrap || en_rise) begin
                    sym_div_l <= sym_div;
                end
            end
        end
    end

    prbs_gen #(.PRBS_LEN(PRBS_LEN)) u_prbs (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (sym_wrap),
        .bit_o (prbs_bit)
    );

`ifdef BPSK_DIFF_ENC_EN
    assign next_bit = diff_en ? (sym_bit ^ prbs_bit) : prbs_bit;
`else
    assign next_bit = prbs_bit;
`endif

    // Symbol bit updates on the same edge that raises sym_strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_bit <= 1'b0;
        end else if (sym_wrap) begin
            sym_bit <= next_bit;
        end
    end

    // Burst window decode; period 0 or on-time covering the period means always on
    always_comb begin
        period_eff = en_rise ? burst_period : period_l;
        on_eff     = en_rise ? burst_on : on_l;
        burst_wrap = (period_eff == '0) || (burst_cnt >= period_eff - BURST_W'(1));
        gate_next  = (period_eff == '0) || (on_eff >= period_eff) || (burst_cnt < on_eff);
    end

    // Burst counter, period/on-time latches and registered gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            period_l  <= '0;
            on_l      <= '0;
            gate      <= 1'b0;
        end else if (!en) begin
            burst_cnt <= '0;
            gate      <= 1'b0;
        end else begin
            gate      <= gate_next;
            burst_cnt <= burst_wrap ? '0 : burst_cnt + BURST_W'(1);
            if (burst_wrap || en_rise) begin
                period_l <= burst_period;
                on_l     <= burst_on;
            end
        end
    end

    // Map symbol to +/-amp, add offset and clip into the DAC code range
    always_comb begin
        mapped = sym_bit ? $signed({1'b0, amp}) : -$signed({1'b0, amp});
        sum    = $signed({2'b00, dac_offset})
               + $signed({{(SUM_W-AMP_W-1){mapped[AMP_W]}}, mapped});
        if (sum[SUM_W-1]) begin
            clip_code = MIN_CODE;
            clip      = 1'b1;
        end else if (sum > SUM_MAX) begin
            clip_code = MAX_CODE;
            clip      = 1'b1;
        end else begin
            clip_code = sum[DAC_W-1:0];
            clip      = 1'b0;
        end
    end

    // Registered DAC code; idle at dac_offset outside the burst window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data <= MID_CODE;
            sat      <= 1'b0;
        end else if (!en || !gate) begin
            dac_data <= dac_offset;
            sat      <= 1'b0;
        end else begin
            dac_data <= clip_code;
            sat      <= clip;
        end
    end

endmodule

// File: tb/tb_bpsk_dac_gen.sv
// Self-checking bench for bpsk_dac_gen (default PRBS-15, DAC_W=14).
// Reference: PRBS bits from the polynomial recurrence on the output stream,
// strobe/gate instants from arithmetic on cycle indices, DAC code by clipped sum.
module tb_bpsk_dac_gen;

    localparam int MAXC = 16383;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
`ifdef BPSK_DIFF_ENC_EN
    logic        diff_en;
`endif
    logic [15:0] sym_div;
    logic [12:0] amp;
    logic [13:0] dac_offset;
    logic [23:0] burst_period;
    logic [23:0] burst_on;
    logic        sym_bit;
    logic        sym_strobe;
    logic        gate;
    logic [13:0] dac_data;
    logic        sat;

    int checks = 0;
    int errors = 0;
    bit g [0:4095];
    int k;
    bit mbit;

    bpsk_dac_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
`ifdef BPSK_DIFF_ENC_EN
        .diff_en      (diff_en),
`endif
        .sym_div      (sym_div),
        .amp          (amp),
        .dac_offset   (dac_offset),
        .burst_period (burst_period),
        .burst_on     (burst_on),
        .sym_bit      (sym_bit),
        .sym_strobe   (sym_strobe),
        .gate         (gate),
        .dac_data     (dac_data),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    // o[n] = o[n-15] ^ o[n-14], history before n=0 is the all-ones seed
    task automatic build_golden;
        bit a, b;
        for (int n = 0; n < 4096; n++) begin
            a = (n < 15) ? 1'b1 : g[n-15];
            b = (n < 14) ? 1'b1 : g[n-14];
            g[n] = a ^ b;
        end
    endtask

    function automatic int dac_model(input bit gt, input bit b, input int a, input int o);
        int s;
        if (!gt) return o;
        s = b ? o + a : o - a;
        if (s < 0) return 0;
        if (s > MAXC) return MAXC;
        return s;
    endfunction

    function automatic bit sat_model(input bit gt, input bit b, input int a, input int o);
        int s;
        s = b ? o + a : o - a;
        return gt && (s < 0 || s > MAXC);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; sym_div = 16'd15; amp = 13'd4096;
        dac_offset = 14'd1234; burst_period = '0; burst_on = '0;
        #12;
        checks++; if (sym_bit !== 1'b0) begin errors++; $display("FAIL reset_sym_bit: got %0d expected 0", sym_bit); end
        checks++; if (sym_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0d expected 0", sym_strobe); end
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %0d expected 0", gate); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0d expected 0", sat); end
        checks++; if (dac_data !== 14'd8192) begin errors++; $display("FAIL reset_dac: got %0d expected 8192", dac_data); end
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (dac_data !== 14'd1234) begin errors++; $display("FAIL idle_dac: got %0d expected 1234", dac_data); end
        k = 0; mbit = 1'b0;
        dac_offset = 14'd8192;
        tick;
    endtask

    task automatic test_symbol_timing;
        bit pbit, pgate, es;
        int e;
        amp = 13'd4096; dac_offset = 14'd8192; sym_div = 16'd15;
        burst_period = '0; burst_on = '0;
        en = 1'b1; pgate = 1'b0;
        for (int i = 1; i <= 320; i++) begin
            tick;
            pbit = mbit;
            es = (i % 16 == 0);
            if (es) begin mbit = g[k]; k++; end
            e = dac_model(pgate, pbit, 4096, 8192);
            checks++; if (sym_strobe !== es) begin errors++; $display("FAIL sym_strobe i=%0d: got %0d expected %0d", i, sym_strobe, es); end
            checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL sym_bit i=%0d: got %0d expected %0d", i, sym_bit, mbit); end
            checks++; if (gate !== 1'b1) begin errors++; $display("FAIL sym_gate i=%0d: got %0d expected 1", i, gate); end
            checks++; if (dac_data !== 14'(e)) begin errors++; $display("FAIL sym_dac i=%0d: got %0d expected %0d", i, dac_data, e); end
            if (i > 1) begin
                checks++;
                if (dac_data !== 14'd12288 && dac_data !== 14'd4096) begin
                    errors++; $display("FAIL sym_dac_set i=%0d: got %0d expected 12288 or 4096", i, dac_data);
                end
            end
            pgate = 1'b1;
        end
        en = 1'b0;
        tick;
    endtask

    task automatic test_mapping;
        int amps [6];
        int offs [6];
        bit pbit, pgate, es;
        int e;
        amps = '{4096, 8191, 8191, 0, 0, 0};
        offs = '{8192, 16000, 100, 0, 0, 0};
        for (int r = 3; r < 6; r++) begin
            amps[r] = $urandom_range(0, 8191);
            offs[r] = $urandom_range(0, 16383);
        end
        sym_div = 16'd0; burst_period = '0; burst_on = '0;
        for (int r = 0; r < 6; r++) begin
            amp = 13'(amps[r]); dac_offset = 14'(offs[r]);
            en = 1'b1; pgate = 1'b0;
            for (int i = 1; i <= 40; i++) begin
                tick;
                pbit = mbit; mbit = g[k]; k++;
                e  = dac_model(pgate, pbit, amps[r], offs[r]);
                es = sat_model(pgate, pbit, amps[r], offs[r]);
                checks++; if (sym_strobe !== 1'b1) begin errors++; $display("FAIL map_strobe r=%0d i=%0d: got %0d expected 1", r, i, sym_strobe); end
                checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL map_bit r=%0d i=%0d: got %0d expected %0d", r, i, sym_bit, mbit); end
                checks++; if (dac_data !== 14'(e)) begin errors++; $display("FAIL map_dac r=%0d i=%0d: got %0d expected %0d", r, i, dac_data, e); end
                checks++; if (sat !== es) begin errors++; $display("FAIL map_sat r=%0d i=%0d: got %0d expected %0d", r, i, sat, es); end
                pgate = 1'b1;
            end
            en = 1'b0;
            tick;
            checks++; if (dac_data !== 14'(offs[r]) || sat !== 1'b0) begin errors++; $display("FAIL map_idle r=%0d: got %0d/%0d expected %0d/0", r, dac_data, sat, offs[r]); end
            checks++; if (sym_bit !== mbit || sym_strobe !== 1'b0) begin errors++; $display("FAIL map_hold r=%0d: got bit %0d strobe %0d expected %0d 0", r, sym_bit, sym_strobe, mbit); end
        end
    endtask

    task automatic test_burst;
        int ons [3];
        int lens [3];
        int a, o, e, nhigh, exp_high;
        bit pbit, pgate, eg, es;
        ons = '{1000, 0, 6000};
        lens = '{10000, 5000, 5000};
        sym_div = 16'd15; burst_period = 24'd5000;
        for (int c = 0; c < 3; c++) begin
            a = $urandom_range(0, 4000);
            o = $urandom_range(4096, 12000);
            amp = 13'(a); dac_offset = 14'(o); burst_on = 24'(ons[c]);
            en = 1'b1; pgate = 1'b0; nhigh = 0;
            for (int i = 1; i <= lens[c]; i++) begin
                tick;
                pbit = mbit;
                if (i % 16 == 0) begin mbit = g[k]; k++; end
                eg = (ons[c] >= 5000) ? 1'b1 : (((i - 1) % 5000) < ons[c]);
                e  = dac_model(pgate, pbit, a, o);
                es = sat_model(pgate, pbit, a, o);
                checks++; if (gate !== eg) begin errors++; $display("FAIL burst_gate c=%0d i=%0d: got %0d expected %0d", c, i, gate, eg); end
                checks++; if (dac_data !== 14'(e)) begin errors++; $display("FAIL burst_dac c=%0d i=%0d: got %0d expected %0d", c, i, dac_data, e); end
                checks++; if (sat !== es) begin errors++; $display("FAIL burst_sat c=%0d i=%0d: got %0d expected %0d", c, i, sat, es); end
                if (gate === 1'b1) nhigh++;
                pgate = eg;
            end
            exp_high = (ons[c] >= 5000) ? lens[c] : (lens[c] / 5000) * ons[c];
            checks++; if (nhigh !== exp_high) begin errors++; $display("FAIL burst_count c=%0d: got %0d expected %0d", c, nhigh, exp_high); end
            en = 1'b0;
            tick;
        end
    endtask

    task automatic test_div_change;
        int next_s;
        bit es;
        sym_div = 16'd15; burst_period = '0; burst_on = '0;
        amp = 13'd1000; dac_offset = 14'd5000;
        en = 1'b1; next_s = 16;
        for (int i = 1; i <= 40; i++) begin
            tick;
            es = (i == next_s);
            if (es) begin mbit = g[k]; k++; next_s = i + int'(sym_div) + 1; end
            checks++; if (sym_strobe !== es) begin errors++; $display("FAIL div_strobe i=%0d: got %0d expected %0d", i, sym_strobe, es); end
            checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL div_bit i=%0d: got %0d expected %0d", i, sym_bit, mbit); end
            if (i == 5) sym_div = 16'd3;
        end
        en = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick;
            checks++; if (sym_strobe !== 1'b0 || gate !== 1'b0) begin errors++; $display("FAIL off_strobe_gate j=%0d: got %0d %0d expected 0 0", j, sym_strobe, gate); end
            checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL off_bit j=%0d: got %0d expected %0d", j, sym_bit, mbit); end
            checks++; if (dac_data !== 14'd5000) begin errors++; $display("FAIL off_dac j=%0d: got %0d expected 5000", j, dac_data); end
        end
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            es = (i % 4 == 0);
            if (es) begin mbit = g[k]; k++; end
            checks++; if (sym_strobe !== es) begin errors++; $display("FAIL reen_strobe i=%0d: got %0d expected %0d", i, sym_strobe, es); end
            checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL reen_bit i=%0d: got %0d expected %0d", i, sym_bit, mbit); end
        end
        en = 1'b0;
        tick;
    endtask

    task automatic test_async_reset;
        bit es;
        sym_div = 16'd3; burst_period = 24'd5000; burst_on = 24'd1000;
        amp = 13'd3000; dac_offset = 14'd8000;
        en = 1'b1;
        for (int i = 1; i <= 50; i++) tick;
        checks++; if (gate !== 1'b1) begin errors++; $display("FAIL pre_rst_gate: got %0d expected 1", gate); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sym_bit !== 1'b0) begin errors++; $display("FAIL arst_bit: got %0d expected 0", sym_bit); end
        checks++; if (sym_strobe !== 1'b0) begin errors++; $display("FAIL arst_strobe: got %0d expected 0", sym_strobe); end
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL arst_gate: got %0d expected 0", gate); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL arst_sat: got %0d expected 0", sat); end
        checks++; if (dac_data !== 14'd8192) begin errors++; $display("FAIL arst_dac: got %0d expected 8192", dac_data); end
        tick;
        rst_n = 1'b1;
        k = 0; mbit = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick;
            es = (i % 4 == 0);
            if (es) begin mbit = g[k]; k++; end
            checks++; if (sym_strobe !== es) begin errors++; $display("FAIL arst_seq_strobe i=%0d: got %0d expected %0d", i, sym_strobe, es); end
            checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL arst_seq_bit i=%0d: got %0d expected %0d", i, sym_bit, mbit); end
        end
        en = 1'b0;
        tick;
    endtask

`ifdef BPSK_DIFF_ENC_EN
    task automatic test_diff;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        k = 0; mbit = 1'b0;
        diff_en = 1'b1; sym_div = 16'd1; burst_period = '0;
        en = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick;
            if (i % 2 == 0) begin mbit = mbit ^ g[k]; k++; end
            checks++; if (sym_bit !== mbit) begin errors++; $display("FAIL diff_bit i=%0d: got %0d expected %0d", i, sym_bit, mbit); end
        end
        en = 1'b0;
        diff_en = 1'b0;
        tick;
    endtask
`endif

    initial begin
`ifdef BPSK_DIFF_ENC_EN
        diff_en = 1'b0;
`endif
        build_golden();
        test_reset();
        test_symbol_timing();
        test_mapping();
        test_burst();
        test_div_change();
        test_async_reset();
`ifdef BPSK_DIFF_ENC_EN
        test_diff();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
